// File: rtl/ysyx_25070198_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25070198_mem_arbiter
// Description : Two-master / one-slave memory arbiter. The instruction fetch
//               unit (read-only) and the load/store unit (read/write) each own
//               a one-entry pending slot. Slots are granted round-robin and one
//               transaction at a time is issued to the slave. The response is
//               routed back to the granted master; a stalled slave is recovered
//               by a timeout that returns zero data and sets a sticky error.
// Ports       : clock, reset_n            - clock / async active-low reset
//               ifu_reqValid, ifu_raddr   - IFU request
//               ifu_respValid, ifu_rdata  - IFU response strobe / data
//               lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
//               lsu_size                  - LSU request
//               lsu_respValid, lsu_rdata  - LSU response strobe / data
//               mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
//               mem_size                  - slave request and payload
//               mem_respValid, mem_rdata  - slave response
//               timeout_err               - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25070198_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_raddr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    input  logic [1:0]  lsu_size,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,

    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [1:0]  mem_size,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,

    output logic        timeout_err
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
    localparam int C_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                             $clog2(TIMEOUT_CYCLES + 1) : 8;
    // The counter is 0 in the first WAIT cycle, so the TIMEOUT_CYCLES-th
    // WAIT cycle is the one where it holds TIMEOUT_CYCLES-1.
    localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         C_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // grant / last_grant encoding: 0 = IFU, 1 = LSU
    state_t               state_q,       state_d;
    logic                 grant_q,       grant_d;
    logic                 last_grant_q,  last_grant_d;
    logic [C_CNT_W-1:0]   cnt_q,         cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 ifu_full_q,    ifu_full_d;
    logic [31:0]          ifu_addr_q,    ifu_addr_d;
    logic                 lsu_full_q,    lsu_full_d;
    logic [31:0]          lsu_addr_q,    lsu_addr_d;
    logic                 lsu_wen_q,     lsu_wen_d;
    logic [31:0]          lsu_wdata_q,   lsu_wdata_d;
    logic [3:0]           lsu_wmask_q,   lsu_wmask_d;
    logic [1:0]           lsu_size_q,    lsu_size_d;

    logic                 w_timeout;
    logic                 w_done;
    logic [31:0]          w_rdata;

    // A real response in the final WAIT cycle takes priority over the timeout.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (state_q == ST_WAIT) &&
                       !mem_respValid && (cnt_q == C_TO_LAST);
    assign w_done    = (state_q == ST_WAIT) && (mem_respValid || w_timeout);
    assign w_rdata   = mem_respValid ? mem_rdata : 32'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            ifu_full_q    <= 1'b0;
            ifu_addr_q    <= 32'h0;
            lsu_full_q    <= 1'b0;
            lsu_addr_q    <= 32'h0;
            lsu_wen_q     <= 1'b0;
            lsu_wdata_q   <= 32'h0;
            lsu_wmask_q   <= 4'h0;
            lsu_size_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            ifu_full_q    <= ifu_full_d;
            ifu_addr_q    <= ifu_addr_d;
            lsu_full_q    <= lsu_full_d;
            lsu_addr_q    <= lsu_addr_d;
            lsu_wen_q     <= lsu_wen_d;
            lsu_wdata_q   <= lsu_wdata_d;
            lsu_wmask_q   <= lsu_wmask_d;
            lsu_size_q    <= lsu_size_d;
        end
    end

    // Next-state, slot capture/release and arbitration.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        ifu_full_d    = ifu_full_q;
        ifu_addr_d    = ifu_addr_q;
        lsu_full_d    = lsu_full_q;
        lsu_addr_d    = lsu_addr_q;
        lsu_wen_d     = lsu_wen_q;
        lsu_wdata_d   = lsu_wdata_q;
        lsu_wmask_d   = lsu_wmask_q;
        lsu_size_d    = lsu_size_q;

        // Capture only into an empty slot; a held level is taken once.
        if (ifu_reqValid && !ifu_full_q) begin
            ifu_full_d = 1'b1;
            ifu_addr_d = ifu_raddr;
        end
        if (lsu_reqValid && !lsu_full_q) begin
            lsu_full_d  = 1'b1;
            lsu_addr_d  = lsu_addr;
            lsu_wen_d   = lsu_wen;
            lsu_wdata_d = lsu_wdata;
            lsu_wmask_d = lsu_wmask;
            lsu_size_d  = lsu_size;
        end

        case (state_q)
            ST_IDLE: begin
                if (ifu_full_q || lsu_full_q) begin
                    state_d = ST_REQ;
                    if (ifu_full_q && lsu_full_q) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = lsu_full_q;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + C_CNT_W'(1);
                if (w_done) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    // Slot was full, so no capture happened this cycle;
                    // a request arriving now is taken next cycle.
                    if (grant_q) begin
                        lsu_full_d = 1'b0;
                    end else begin
                        ifu_full_d = 1'b0;
                    end
                    if (w_timeout) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from state only (plus the slave response), so an
    // asynchronous reset forces them to zero immediately.
    always_comb begin
        mem_reqValid  = (state_q == ST_REQ);
        mem_addr      = 32'h0;
        mem_wen       = 1'b0;
        mem_wdata     = 32'h0;
        mem_wmask     = 4'h0;
        mem_size      = 2'b00;
        if (state_q != ST_IDLE) begin
            if (grant_q) begin
                mem_addr  = lsu_addr_q;
                mem_wen   = lsu_wen_q;
                mem_wdata = lsu_wdata_q;
                mem_wmask = lsu_wmask_q;
                mem_size  = lsu_size_q;
            end else begin
                mem_addr  = ifu_addr_q;
                mem_size  = C_SIZE_WORD;
            end
        end

        ifu_respValid = w_done && !grant_q;
        lsu_respValid = w_done &&  grant_q;
        ifu_rdata     = ifu_respValid ? w_rdata : 32'h0;
        lsu_rdata     = lsu_respValid ? w_rdata : 32'h0;
        timeout_err   = timeout_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25070198_mem_arbiter
// Description : Directed self-checking bench for ysyx_25070198_mem_arbiter.
//               Expected slave payloads are queued when a master request is
//               driven and popped when the arbiter issues mem_reqValid;
//               expected response data is queued when the slave answers and
//               popped when the master strobe is checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25070198_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ifu_reqValid;
    logic [31:0] ifu_raddr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [1:0]  lsu_size;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [1:0]  mem_size;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  size;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rsp_q[$];

    always #5 clock = ~clock;

    ysyx_25070198_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_raddr     (ifu_raddr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_size      (lsu_size),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .mem_reqValid  (mem_reqValid),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_size      (mem_size),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_ifu(input logic [31:0] a);
        txn_t t;
        t = '{addr: a, wen: 1'b0, wdata: 32'h0, wmask: 4'h0, size: 2'b10};
        exp_q.push_back(t);
    endtask

    task automatic push_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] m, input logic [1:0] s);
        txn_t t;
        t = '{addr: a, wen: w, wdata: d, wmask: m, size: s};
        exp_q.push_back(t);
    endtask

    // Called in the REQ cycle: checks the strobe and pops/compares the payload.
    task automatic req_phase(input string tag, output txn_t t);
        chk({tag, "_reqv"}, 32'(mem_reqValid), 32'd1);
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed=empty expected=queued_txn", tag);
        end
        t = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk({tag, "_addr"},  mem_addr,           t.addr);
        chk({tag, "_wen"},   32'(mem_wen),       32'(t.wen));
        chk({tag, "_wdata"}, mem_wdata,          t.wdata);
        chk({tag, "_wmask"}, 32'(mem_wmask),     32'(t.wmask));
        chk({tag, "_size"},  32'(mem_size),      32'(t.size));
    endtask

    // From the REQ cycle: slave answers in WAIT cycle 'delay' with 'rdata'.
    task automatic serve(input bit is_lsu, input logic [31:0] rdata, input int delay,
                         input string tag);
        txn_t        t;
        logic [31:0] r;
        req_phase(tag, t);
        for (int i = 1; i <= delay; i++) begin
            step();
            chk({tag, "_wait_reqv"}, 32'(mem_reqValid), 32'd0);
            chk({tag, "_hold_addr"}, mem_addr, t.addr);
            if (i < delay) begin
                chk({tag, "_early_resp"}, 32'({ifu_respValid, lsu_respValid}), 32'd0);
            end
        end
        mem_respValid = 1'b1;
        mem_rdata     = rdata;
        rsp_q.push_back(rdata);
        if (is_lsu) lsu_reqValid = 1'b0;
        else        ifu_reqValid = 1'b0;
        #1;
        r = rsp_q.pop_front();
        if (is_lsu) begin
            chk({tag, "_lsu_resp"},  32'(lsu_respValid), 32'd1);
            chk({tag, "_lsu_rdata"}, lsu_rdata,          r);
            chk({tag, "_ifu_quiet"}, 32'(ifu_respValid), 32'd0);
            chk({tag, "_ifu_rd0"},   ifu_rdata,          32'h0);
        end else begin
            chk({tag, "_ifu_resp"},  32'(ifu_respValid), 32'd1);
            chk({tag, "_ifu_rdata"}, ifu_rdata,          r);
            chk({tag, "_lsu_quiet"}, 32'(lsu_respValid), 32'd0);
            chk({tag, "_lsu_rd0"},   lsu_rdata,          32'h0);
        end
        step();
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        #1;
        chk({tag, "_one_strobe"}, 32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk({tag, "_idle_reqv"},  32'(mem_reqValid), 32'd0);
        chk({tag, "_idle_addr"},  mem_addr,          32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        int   nreq;

        reset_n       = 1'b0;
        ifu_reqValid  = 1'b0;
        ifu_raddr     = 32'h0;
        lsu_reqValid  = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 4'h0;
        lsu_size      = 2'b00;
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;

        // ---- reset state ----
        step(); step();
        chk("rst_mem_reqv", 32'(mem_reqValid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        chk("rst_resp",     32'({ifu_respValid, lsu_respValid}), 32'd0);
        chk("rst_err",      32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        step();

        // ---- IFU-only fetch ----
        ifu_reqValid = 1'b1;
        ifu_raddr    = 32'h3000_0000;
        push_ifu(32'h3000_0000);
        step();
        ifu_reqValid = 1'b0;
        #1;
        chk("ifu_lat_idle", 32'(mem_reqValid), 32'd0);
        step();
        serve(1'b0, 32'h0000_0413, 1, "ifu_fetch");

        // ---- LSU store byte ----
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h8000_0003;
        lsu_wen      = 1'b1;
        lsu_wmask    = 4'b1000;
        lsu_wdata    = 32'hAB00_0000;
        lsu_size     = 2'b00;
        push_lsu(32'h8000_0003, 1'b1, 32'hAB00_0000, 4'b1000, 2'b00);
        step();
        lsu_reqValid = 1'b0;
        step();
        serve(1'b1, 32'h0, 2, "lsu_sb");

        // ---- level-held LSU read ----
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h8000_0040;
        lsu_wen      = 1'b0;
        lsu_wmask    = 4'h0;
        lsu_wdata    = 32'h0;
        lsu_size     = 2'b10;
        push_lsu(32'h8000_0040, 1'b0, 32'h0, 4'h0, 2'b10);
        step();
        step();
        serve(1'b1, 32'h1122_3344, 2, "lsu_level");
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_reqValid) nreq++;
            step();
        end
        chk("lsu_level_single_req", 32'(nreq), 32'd0);

        // ---- simultaneous requests after reset ----
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        for (int rep = 0; rep < 2; rep++) begin
            ifu_reqValid = 1'b1;
            ifu_raddr    = 32'h3000_0100 + 32'(rep);
            lsu_reqValid = 1'b1;
            lsu_addr     = 32'h8000_0200 + 32'(rep);
            lsu_wen      = 1'b1;
            lsu_wdata    = 32'h5A5A_0000 + 32'(rep);
            lsu_wmask    = 4'b1111;
            lsu_size     = 2'b10;
            push_lsu(32'h8000_0200 + 32'(rep), 1'b1, 32'h5A5A_0000 + 32'(rep), 4'b1111, 2'b10);
            push_ifu(32'h3000_0100 + 32'(rep));
            step();
            ifu_reqValid = 1'b0;
            lsu_reqValid = 1'b0;
            step();
            serve(1'b1, 32'h0, 1, "tie_lsu_first");
            step();
            serve(1'b0, 32'hDEAD_0000 + 32'(rep), 1, "tie_ifu_second");
        end

        // ---- response coinciding with the timeout cycle ----
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h8000_0300;
        lsu_wen      = 1'b0;
        lsu_wdata    = 32'h0;
        lsu_wmask    = 4'h0;
        lsu_size     = 2'b10;
        push_lsu(32'h8000_0300, 1'b0, 32'h0, 4'h0, 2'b10);
        step();
        lsu_reqValid = 1'b0;
        step();
        serve(1'b1, 32'hCAFE_F00D, 4, "race");
        chk("race_no_err", 32'(timeout_err), 32'd0);

        // ---- timeout ----
        ifu_reqValid = 1'b1;
        ifu_raddr    = 32'h3000_0010;
        push_ifu(32'h3000_0010);
        step();
        ifu_reqValid = 1'b0;
        step();
        req_phase("to", t);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("to_early_resp", 32'(ifu_respValid), 32'd0);
        end
        step();
        chk("to_resp",       32'(ifu_respValid), 32'd1);
        chk("to_rdata",      ifu_rdata,          32'h0);
        chk("to_lsu_quiet",  32'(lsu_respValid), 32'd0);
        step();
        chk("to_err_set",    32'(timeout_err),   32'd1);
        chk("to_one_strobe", 32'(ifu_respValid), 32'd0);
        mem_respValid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
        #1;
        chk("stray_ifu",     32'(ifu_respValid), 32'd0);
        chk("stray_lsu",     32'(lsu_respValid), 32'd0);
        chk("stray_rdata",   ifu_rdata,          32'h0);
        step();
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        step();
        chk("stray_no_req",  32'(mem_reqValid),  32'd0);
        chk("to_err_sticky", 32'(timeout_err),   32'd1);

        // ---- reset mid-WAIT ----
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h8000_0404;
        lsu_wen      = 1'b1;
        lsu_wdata    = 32'h1234_5678;
        lsu_wmask    = 4'b0011;
        lsu_size     = 2'b01;
        push_lsu(32'h8000_0404, 1'b1, 32'h1234_5678, 4'b0011, 2'b01);
        step();
        lsu_reqValid = 1'b0;
        step();
        req_phase("rstw", t);
        step();
        chk("rstw_in_wait", mem_addr, 32'h8000_0404);
        reset_n = 1'b0;
        #1;
        chk("rstw_addr",  mem_addr,            32'h0);
        chk("rstw_wen",   32'(mem_wen),        32'd0);
        chk("rstw_wdata", mem_wdata,           32'h0);
        chk("rstw_wmask", 32'(mem_wmask),      32'd0);
        chk("rstw_size",  32'(mem_size),       32'd0);
        chk("rstw_err",   32'(timeout_err),    32'd0);
        step();
        reset_n = 1'b1;
        step();
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0055;
        #1;
        chk("rstw_late_resp",  32'(lsu_respValid), 32'd0);
        chk("rstw_late_rdata", lsu_rdata,          32'h0);
        step();
        mem_respValid = 1'b0;
        mem_rdata     = 32'h0;
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_reqValid) nreq++;
            step();
        end
        chk("rstw_slots_empty", 32'(nreq), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
